reversi_control: RTL and testbench

Control FSM for the Reversi game, directly upstream of the datapath. It turns board keys into one-hot datapath enables, sequences the datapath's multi-cycle drawing and rule operations using the datapath's `go`, `validMove` and `hasTurn` outputs, and tracks whose turn it is and when the game is over. It resets the datapath itself and contains no board state.

---
 rtl/reversi_pkg.sv | 48 ++++
 rtl/reversi_control_key_edge_sync.sv | 33 +++
 rtl/reversi_control.sv | 227 ++++++++++++++++++++++
 tb/tb_reversi_control.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reversi_pkg.sv
// reversi_pkg: types and constants shared by the Reversi control FSM.
//   stateT      - control FSM state encoding
//   BLACK/WHITE - encoding of the player output
//   keySelT     - selected key, with pickKey() giving enter > up > down > left > right
//   GO_TIMEOUT_DEFAULT - default wait-state timeout in cycles
`timescale 1ns/1ps
package reversi_pkg;

  localparam int GO_TIMEOUT_DEFAULT = 1 << 20;

  localparam logic BLACK = 1'b0;
  localparam logic WHITE = 1'b1;

  typedef enum logic [3:0] {
    S_RST, S_BOARD, S_INIT, S_HL, S_KEY, S_MOVE, S_CHECK, S_PLACE,
    S_FLIP, S_SCORE, S_OPP, S_TURN, S_CUR, S_RMHL, S_OVER
  } stateT;

  // Bit positions in the key-edge vector; lower index wins.
  localparam int KEY_ENTER = 0;
  localparam int KEY_UP    = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_LEFT  = 3;
  localparam int KEY_RIGHT = 4;

  typedef enum logic [2:0] {
    K_NONE, K_ENTER, K_UP, K_DOWN, K_LEFT, K_RIGHT
  } keySelT;

  function automatic keySelT pickKey(input logic [4:0] edges);
    if (edges[KEY_ENTER]) return K_ENTER;
    if (edges[KEY_UP])    return K_UP;
    if (edges[KEY_DOWN])  return K_DOWN;
    if (edges[KEY_LEFT])  return K_LEFT;
    if (edges[KEY_RIGHT]) return K_RIGHT;
    return K_NONE;
  endfunction

  // States that advance only on the datapath's go flag.
  function automatic logic isWaitState(input stateT s);
    case (s)
      S_RST, S_BOARD, S_INIT, S_HL, S_CHECK, S_PLACE,
      S_FLIP, S_SCORE, S_OPP, S_CUR, S_RMHL: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reversi_control_key_edge_sync.sv
// key_edge_sync: two-flop synchronizer followed by a registered rising-edge
// detector for one asynchronous push-button level.
//   clk      - system clock
//   resetn   - synchronous, active-high reset
//   keyLevel - raw asynchronous key level
//   keyRise  - one-cycle pulse, three clock edges after the level rises
`timescale 1ns/1ps
module key_edge_sync (
  input  logic clk,
  input  logic resetn,
  input  logic keyLevel,
  output logic keyRise
);

  logic meta;
  logic sync;
  logic syncDly;

  always_ff @(posedge clk) begin
    if (resetn) begin
      meta    <= 1'b0;
      sync    <= 1'b0;
      syncDly <= 1'b0;
      keyRise <= 1'b0;
    end else begin
      meta    <= keyLevel;
      sync    <= meta;
      syncDly <= sync;
      keyRise <= sync & ~syncDly;
    end
  end

endmodule

// File: rtl/reversi_control.sv
// reversi_control: control FSM sitting directly upstream of the Reversi
// datapath. Sequences draw / rule operations on the datapath go flag, turns
// key edges into move / enter pulses, tracks the player and game over, and
// flags a sticky fault when a wait state exceeds GO_TIMEOUT cycles.
//   clk, resetn            - clock, synchronous active-high reset
//   key_*                  - raw asynchronous push-button levels
//   go, validMove, hasTurn - datapath handshake and results
//   dp_reset, *En, determine* - Moore datapath enables
//   player, game_over, fault  - status
//
// state   | meaning
// S_RST   | datapath reset, wait go
// S_BOARD | draw empty board
// S_INIT  | draw the four starting pieces
// S_HL    | highlight cursor square
// S_KEY   | idle, waiting for a key edge
// S_MOVE  | one-cycle cursor move pulse
// S_CHECK | test validity of the cursor square
// S_PLACE | place piece
// S_FLIP  | flip captured pieces
// S_SCORE | update score
// S_OPP   | does the opponent have a legal move
// S_TURN  | one-cycle hand-over, player toggles
// S_CUR   | opponent passes: does the current player have a move
// S_RMHL  | remove highlight before game over
// S_OVER  | game over, enter restarts
`timescale 1ns/1ps
module reversi_control
  import reversi_pkg::*;
#(
  parameter int GO_TIMEOUT = GO_TIMEOUT_DEFAULT,
  parameter int TW         = 21
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_enter,
  input  logic key_up,
  input  logic key_down,
  input  logic key_left,
  input  logic key_right,
  input  logic go,
  input  logic validMove,
  input  logic hasTurn,
  output logic dp_reset,
  output logic writeEn,
  output logic drawBoardEn,
  output logic drawInitialPiecesEn,
  output logic moveHighlightEn,
  output logic checkIfValidMoveEn,
  output logic placeEn,
  output logic flipEn,
  output logic scoreManagerEn,
  output logic determineHasTurnEn,
  output logic determineOpponent,
  output logic determineCurrent,
  output logic TurnManagerEn,
  output logic removeHighlightEn,
  output logic moveUpEn,
  output logic moveDownEn,
  output logic moveLeftEn,
  output logic moveRightEn,
  output logic enterEn,
  output logic player,
  output logic game_over,
  output logic fault
);

  localparam logic [TW-1:0] CNT_LAST = TW'(GO_TIMEOUT - 1);

  stateT   state, stateNext;
  keySelT  keySel, moveDir;
  logic [4:0]    keyRaw, keyEdge;
  logic [TW-1:0] cnt;
  logic          goOk, timeout;

  assign keyRaw[KEY_ENTER] = key_enter;
  assign keyRaw[KEY_UP]    = key_up;
  assign keyRaw[KEY_DOWN]  = key_down;
  assign keyRaw[KEY_LEFT]  = key_left;
  assign keyRaw[KEY_RIGHT] = key_right;

  for (genvar i = 0; i < 5; i++) begin : gKey
    key_edge_sync uSync (
      .clk     (clk),
      .resetn  (resetn),
      .keyLevel(keyRaw[i]),
      .keyRise (keyEdge[i])
    );
  end

  // Edges are single-cycle, so anything outside S_KEY/S_OVER is simply lost.
  assign keySel = pickKey(keyEdge);

  always_ff @(posedge clk) begin
    if (resetn) begin
      state   <= S_RST;
      cnt     <= '0;
      moveDir <= K_NONE;
      player  <= BLACK;
      fault   <= 1'b0;
    end else begin
      state <= stateNext;
      // Restart the dwell count on every transition, including the
      // S_RST -> S_RST timeout.
      if (stateNext != state || timeout) cnt <= '0;
      else if (isWaitState(state))       cnt <= cnt + TW'(1);
      if (state == S_KEY) moveDir <= keySel;
      if (state == S_TURN)                          player <= ~player;
      else if (state == S_OVER && keySel == K_ENTER) player <= BLACK;
      if (timeout) fault <= 1'b1;
    end
  end

  always_comb begin
    stateNext           = state;
    // First cycle of a wait state ignores go: it may be the last
    // operation's done flag still held by the datapath.
    goOk                = go && (cnt != '0);
    timeout             = 1'b0;
    dp_reset            = 1'b0;
    writeEn             = 1'b0;
    drawBoardEn         = 1'b0;
    drawInitialPiecesEn = 1'b0;
    moveHighlightEn     = 1'b0;
    checkIfValidMoveEn  = 1'b0;
    placeEn             = 1'b0;
    flipEn              = 1'b0;
    scoreManagerEn      = 1'b0;
    determineHasTurnEn  = 1'b0;
    determineOpponent   = 1'b0;
    determineCurrent    = 1'b0;
    TurnManagerEn       = 1'b0;
    removeHighlightEn   = 1'b0;
    moveUpEn            = 1'b0;
    moveDownEn          = 1'b0;
    moveLeftEn          = 1'b0;
    moveRightEn         = 1'b0;
    enterEn             = 1'b0;
    game_over           = 1'b0;

    case (state)
      S_RST: begin
        dp_reset = 1'b1;
        if (goOk) stateNext = S_BOARD;
      end
      S_BOARD: begin
        drawBoardEn = 1'b1;
        writeEn     = 1'b1;
        if (goOk) stateNext = S_INIT;
      end
      S_INIT: begin
        drawInitialPiecesEn = 1'b1;
        writeEn             = 1'b1;
        if (goOk) stateNext = S_HL;
      end
      S_HL: begin
        moveHighlightEn = 1'b1;
        writeEn         = 1'b1;
        if (goOk) stateNext = S_KEY;
      end
      S_KEY: begin
        case (keySel)
          K_NONE:  stateNext = S_KEY;
          K_ENTER: stateNext = S_CHECK;
          default: stateNext = S_MOVE;
        endcase
      end
      S_MOVE: begin
        moveUpEn    = (moveDir == K_UP);
        moveDownEn  = (moveDir == K_DOWN);
        moveLeftEn  = (moveDir == K_LEFT);
        moveRightEn = (moveDir == K_RIGHT);
        stateNext   = S_HL;
      end
      S_CHECK: begin
        checkIfValidMoveEn = 1'b1;
        enterEn            = (cnt == '0);
        if (goOk) stateNext = validMove ? S_PLACE : S_KEY;
      end
      S_PLACE: begin
        placeEn = 1'b1;
        writeEn = 1'b1;
        if (goOk) stateNext = S_FLIP;
      end
      S_FLIP: begin
        flipEn  = 1'b1;
        writeEn = 1'b1;
        if (goOk) stateNext = S_SCORE;
      end
      S_SCORE: begin
        scoreManagerEn = 1'b1;
        writeEn        = 1'b1;
        if (goOk) stateNext = S_OPP;
      end
      S_OPP: begin
        determineHasTurnEn = 1'b1;
        determineOpponent  = 1'b1;
        if (goOk) stateNext = hasTurn ? S_TURN : S_CUR;
      end
      S_TURN: begin
        TurnManagerEn = 1'b1;
        stateNext     = S_HL;
      end
      S_CUR: begin
        determineHasTurnEn = 1'b1;
        determineCurrent   = 1'b1;
        if (goOk) stateNext = hasTurn ? S_HL : S_RMHL;
      end
      S_RMHL: begin
        removeHighlightEn = 1'b1;
        writeEn           = 1'b1;
        if (goOk) stateNext = S_OVER;
      end
      S_OVER: begin
        game_over = 1'b1;
        if (keySel == K_ENTER) stateNext = S_RST;
      end
      default: stateNext = S_RST;
    endcase

    if (isWaitState(state) && !goOk && cnt == CNT_LAST) begin
      timeout   = 1'b1;
      stateNext = S_RST;
    end
  end

endmodule

// File: tb/tb_reversi_control.sv
// tb_reversi_control: directed self-checking bench for reversi_control.
// Outputs are packed into one vector and compared against per-state
// expected patterns written out by hand.
`timescale 1ns/1ps
module tb_reversi_control;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic key_enter = 0, key_up = 0, key_down = 0, key_left = 0, key_right = 0;
  logic go = 0, validMove = 0, hasTurn = 0;
  logic dp_reset, writeEn, drawBoardEn, drawInitialPiecesEn, moveHighlightEn;
  logic checkIfValidMoveEn, placeEn, flipEn, scoreManagerEn, determineHasTurnEn;
  logic determineOpponent, determineCurrent, TurnManagerEn, removeHighlightEn;
  logic moveUpEn, moveDownEn, moveLeftEn, moveRightEn, enterEn;
  logic player, game_over, fault;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  reversi_control #(.GO_TIMEOUT(16), .TW(5)) dut (
    .clk(clk), .resetn(resetn),
    .key_enter(key_enter), .key_up(key_up), .key_down(key_down),
    .key_left(key_left), .key_right(key_right),
    .go(go), .validMove(validMove), .hasTurn(hasTurn),
    .dp_reset(dp_reset), .writeEn(writeEn), .drawBoardEn(drawBoardEn),
    .drawInitialPiecesEn(drawInitialPiecesEn), .moveHighlightEn(moveHighlightEn),
    .checkIfValidMoveEn(checkIfValidMoveEn), .placeEn(placeEn), .flipEn(flipEn),
    .scoreManagerEn(scoreManagerEn), .determineHasTurnEn(determineHasTurnEn),
    .determineOpponent(determineOpponent), .determineCurrent(determineCurrent),
    .TurnManagerEn(TurnManagerEn), .removeHighlightEn(removeHighlightEn),
    .moveUpEn(moveUpEn), .moveDownEn(moveDownEn), .moveLeftEn(moveLeftEn),
    .moveRightEn(moveRightEn), .enterEn(enterEn),
    .player(player), .game_over(game_over), .fault(fault)
  );

  // bit 19 dp_reset ... bit 0 game_over
  logic [19:0] outVec;
  assign outVec = {dp_reset, writeEn, drawBoardEn, drawInitialPiecesEn,
                   moveHighlightEn, checkIfValidMoveEn, placeEn, flipEn,
                   scoreManagerEn, determineHasTurnEn, determineOpponent,
                   determineCurrent, TurnManagerEn, removeHighlightEn,
                   moveUpEn, moveDownEn, moveLeftEn, moveRightEn, enterEn,
                   game_over};

  localparam logic [19:0] B1 = 20'h1;
  localparam logic [19:0] W      = B1 << 18;
  localparam logic [19:0] E_RST   = B1 << 19;
  localparam logic [19:0] E_BOARD = W | (B1 << 17);
  localparam logic [19:0] E_INIT  = W | (B1 << 16);
  localparam logic [19:0] E_HL    = W | (B1 << 15);
  localparam logic [19:0] E_KEY   = 20'h0;
  localparam logic [19:0] E_CHECK = B1 << 14;
  localparam logic [19:0] E_ENTER = E_CHECK | (B1 << 1);
  localparam logic [19:0] E_PLACE = W | (B1 << 13);
  localparam logic [19:0] E_FLIP  = W | (B1 << 12);
  localparam logic [19:0] E_SCORE = W | (B1 << 11);
  localparam logic [19:0] E_OPP   = (B1 << 10) | (B1 << 9);
  localparam logic [19:0] E_CUR   = (B1 << 10) | (B1 << 8);
  localparam logic [19:0] E_TURN  = B1 << 7;
  localparam logic [19:0] E_RMHL  = W | (B1 << 6);
  localparam logic [19:0] E_MUP   = B1 << 5;
  localparam logic [19:0] E_MRGT  = B1 << 2;
  localparam logic [19:0] E_OVER  = B1;

  localparam logic [4:0] K_ENT = 5'b00001;
  localparam logic [4:0] K_UPL = 5'b01010;
  localparam logic [4:0] K_RGT = 5'b10000;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setKeys(input logic [4:0] m);
    {key_right, key_left, key_down, key_up, key_enter} = m;
  endtask

  // Called in the first cycle of a wait state; datapath raises go in cycle 3.
  task automatic serve(input string tag, input logic [19:0] entryExp,
                       input logic [19:0] exp, input logic vm, input logic ht);
    checkVal({tag, "_entry"}, 32'(outVec), 32'(entryExp));
    tick;
    tick;
    checkVal({tag, "_hold"}, 32'(outVec), 32'(exp));
    go = 1'b1; validMove = vm; hasTurn = ht;
    tick;
    go = 1'b0; validMove = 1'b0; hasTurn = 1'b0;
  endtask

  // Key level change; the FSM reacts on the 4th edge afterwards.
  task automatic pressKey(input string tag, input logic [4:0] m, input logic [19:0] idleExp);
    setKeys(m);
    repeat (3) tick;
    checkVal({tag, "_lat3"}, 32'(outVec), 32'(idleExp));
    tick;
    setKeys(5'b0);
  endtask

  task automatic startup(input string tag);
    serve({tag, "_rst"},   E_RST,   E_RST,   1'b0, 1'b0);
    serve({tag, "_board"}, E_BOARD, E_BOARD, 1'b0, 1'b0);
    serve({tag, "_init"},  E_INIT,  E_INIT,  1'b0, 1'b0);
    serve({tag, "_hl"},    E_HL,    E_HL,    1'b0, 1'b0);
    checkVal({tag, "_key"}, 32'(outVec), 32'(E_KEY));
  endtask

  task automatic toOpp(input string tag);
    pressKey({tag, "_ent"}, K_ENT, E_KEY);
    serve({tag, "_chk"},   E_ENTER, E_CHECK, 1'b1, 1'b0);
    serve({tag, "_place"}, E_PLACE, E_PLACE, 1'b0, 1'b0);
    serve({tag, "_flip"},  E_FLIP,  E_FLIP,  1'b0, 1'b0);
    serve({tag, "_score"}, E_SCORE, E_SCORE, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;

    repeat (3) tick;
    checkVal("reset_out", 32'(outVec), 32'(E_RST));
    checkVal("reset_player", 32'(player), 32'(0));
    checkVal("reset_fault", 32'(fault), 32'(0));
    resetn = 1'b0;

    startup("start");
    checkVal("start_player", 32'(player), 32'(0));

    // single move right
    pressKey("mvr", K_RGT, E_KEY);
    checkVal("mvr_pulse", 32'(outVec), 32'(E_MRGT));
    tick;
    serve("mvr_hl", E_HL, E_HL, 1'b0, 1'b0);
    checkVal("mvr_key", 32'(outVec), 32'(E_KEY));

    // right held 1000 cycles, datapath answering highlight immediately
    setKeys(K_RGT);
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      go = moveHighlightEn;
      tick;
      if (moveRightEn) pulses++;
    end
    go = 1'b0;
    setKeys(5'b0);
    repeat (4) tick;
    checkVal("hold_pulses", 32'(pulses), 32'(1));
    checkVal("hold_key", 32'(outVec), 32'(E_KEY));

    // invalid move
    pressKey("inv", K_ENT, E_KEY);
    serve("inv_chk", E_ENTER, E_CHECK, 1'b0, 1'b0);
    checkVal("inv_back", 32'(outVec), 32'(E_KEY));

    // valid move, opponent can play
    toOpp("val");
    serve("val_opp", E_OPP, E_OPP, 1'b0, 1'b1);
    checkVal("val_turn", 32'(outVec), 32'(E_TURN));
    checkVal("val_player0", 32'(player), 32'(0));
    tick;
    checkVal("val_player1", 32'(player), 32'(1));
    serve("val_hl", E_HL, E_HL, 1'b0, 1'b0);

    // opponent passes
    toOpp("pass");
    serve("pass_opp", E_OPP, E_OPP, 1'b0, 1'b0);
    serve("pass_cur", E_CUR, E_CUR, 1'b0, 1'b1);
    checkVal("pass_player", 32'(player), 32'(1));
    serve("pass_hl", E_HL, E_HL, 1'b0, 1'b0);

    // nobody can move: game over
    toOpp("end");
    serve("end_opp", E_OPP, E_OPP, 1'b0, 1'b0);
    serve("end_cur", E_CUR, E_CUR, 1'b0, 1'b0);
    serve("end_rmhl", E_RMHL, E_RMHL, 1'b0, 1'b0);
    checkVal("end_over", 32'(outVec), 32'(E_OVER));
    repeat (3) tick;
    checkVal("end_over_hold", 32'(outVec), 32'(E_OVER));
    pressKey("restart", K_ENT, E_OVER);
    checkVal("restart_out", 32'(outVec), 32'(E_RST));
    checkVal("restart_player", 32'(player), 32'(0));

    startup("start2");

    // simultaneous up + left: only up acts, left is not queued
    pressKey("simul", K_UPL, E_KEY);
    checkVal("simul_pulse", 32'(outVec), 32'(E_MUP));
    tick;
    serve("simul_hl", E_HL, E_HL, 1'b0, 1'b0);
    repeat (5) tick;
    checkVal("simul_noqueue", 32'(outVec), 32'(E_KEY));

    // stale go across PLACE -> FLIP, then FLIP times out
    pressKey("stale", K_ENT, E_KEY);
    serve("stale_chk", E_ENTER, E_CHECK, 1'b1, 1'b0);
    checkVal("stale_place", 32'(outVec), 32'(E_PLACE));
    tick;
    tick;
    go = 1'b1;
    tick;
    checkVal("stale_flip_entry", 32'(outVec), 32'(E_FLIP));
    tick;
    checkVal("stale_flip_dwell", 32'(outVec), 32'(E_FLIP));
    go = 1'b0;
    repeat (14) tick;
    checkVal("tmo_before_out", 32'(outVec), 32'(E_FLIP));
    checkVal("tmo_before_fault", 32'(fault), 32'(0));
    tick;
    checkVal("tmo_out", 32'(outVec), 32'(E_RST));
    checkVal("tmo_fault", 32'(fault), 32'(1));

    startup("start3");
    checkVal("fault_sticky", 32'(fault), 32'(1));

    // reset in the middle of FLIP
    pressKey("rstmid", K_ENT, E_KEY);
    serve("rstmid_chk", E_ENTER, E_CHECK, 1'b1, 1'b0);
    serve("rstmid_place", E_PLACE, E_PLACE, 1'b0, 1'b0);
    checkVal("rstmid_flip", 32'(outVec), 32'(E_FLIP));
    tick;
    resetn = 1'b1;
    tick;
    resetn = 1'b0;
    checkVal("rstmid_out", 32'(outVec), 32'(E_RST));
    checkVal("rstmid_fault", 32'(fault), 32'(0));
    checkVal("rstmid_player", 32'(player), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
